pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised fetch program-counter unit for the cached RISC-V core; successor to the single-register PC.
//  Selects next PC by priority: trap, mret, EX redirect, RAS return prediction, sequential.
//  Holds on I-cache/hazard stall, captures EPC on trap, owns a circular return-address stack (RAS).
//  Sits between hazard/cache-control logic and the instruction-cache address port.
// PARAMETERS
//  WIDTH        32            PC / address width in bits
//  RESET_VECTOR 32'h0000_0000 PC value after reset
//  TRAP_VECTOR  32'h0000_0100 PC loaded on trap
//  INC          4             sequential increment (bytes)
//  RAS_DEPTH    4             RAS entries (power of 2, >=2)
// PORTS
//  CLK             in  1     clock, rising edge
//  RST             in  1     synchronous active-low reset
//  Stall           in  1     hold PC (cache miss / load-use)
//  trap_valid      in  1     take trap this cycle
//  trap_pc         in  WIDTH PC of trapping instruction
//  mret_valid      in  1     return from trap
//  redirect_valid  in  1     branch/jump resolved taken in EX
//  redirect_target in  WIDTH EX target address
//  call_push       in  1     decode saw call (JAL/JALR rd=x1/x5)
//  call_ret_addr   in  WIDTH return address to push
//  ret_pop         in  1     decode saw return (JALR rs1=x1/x5, rd=x0)
//  PC              out WIDTH current fetch address
//  PCPlus          out WIDTH PC + INC, combinational
//  epc             out WIDTH saved exception PC
//  ras_empty       out 1     RAS count == 0
//  ras_full        out 1     RAS count == RAS_DEPTH
//  misalign_err    out 1     one-cycle pulse: accepted redirect target had bits[1:0] != 0
// BEHAVIOUR
//  Reset (RST==0 at posedge): PC=RESET_VECTOR, epc=0, RAS count/ptr=0, misalign_err=0; reset dominates all inputs.
//  All state updates on posedge CLK; next-PC selection is one cycle (PC visible the cycle after the event).
//  Priority per cycle, highest first:
//   1 trap_valid: PC<=TRAP_VECTOR, epc<=trap_pc, RAS flushed (count=0). Overrides Stall.
//   2 mret_valid: PC<=epc. Overrides Stall. RAS untouched.
//   3 redirect_valid: PC<={redirect_target[W-1:2],2'b00}; misalign_err<=|redirect_target[1:0]. Overrides Stall.
//   4 Stall: PC held; call_push/ret_pop ignored (no RAS change).
//   5 ret_pop & !ras_empty: PC<=RAS top, count-1.
//   6 otherwise: PC<=PC+INC, wrapping modulo 2^WIDTH.
//  misalign_err is 0 in every cycle without an accepted redirect.
//  RAS ops are applied only when the cycle selects case 5 or 6; higher-priority events cancel them.
//  ret_pop with ras_empty: no prediction, sequential PC, count stays 0.
//  push & pop same cycle (non-empty): PC<=old top; top overwritten by call_ret_addr; count unchanged.
//  push & pop same cycle (empty): push only; PC sequential.
//  Push when full: circular overwrite of the oldest entry; count stays RAS_DEPTH.
//  Top pointer wraps modulo RAS_DEPTH.
//  Simultaneous trap+mret+redirect: trap wins, the others are dropped.
// STRUCTURE
//  pc_pkg: WIDTH default, RESET_VECTOR, TRAP_VECTOR, INC constants, and the next-PC select encoding
//   (SEL_TRAP, SEL_MRET, SEL_REDIR, SEL_HOLD, SEL_RAS, SEL_SEQ).
//  Sub-module ras_stack (params WIDTH, RAS_DEPTH).
//   Ports: CLK, RST, flush, push, pop, push_data, top, empty, full.
//   Holds the pointer/count logic and all wrap rules.
//  pc_unit: priority select plus PC, epc and misalign_err registers.
// TESTING
//  1 Reset, then 3 free cycles -> PC=0,4,8,C; epc=0; ras_empty=1.
//  2 PC=0x10, Stall=1 for 2 cycles with redirect_valid=1 in cycle 2 (target 0x40)
//    -> PC stays 0x10 in cycle 1, then 0x40; misalign_err=0.
//  3 redirect target 0x42 -> PC=0x40; misalign_err=1 for exactly one cycle.
//  4 Push 0xA0,0xB0,0xC0,0xD0,0xE0 (RAS_DEPTH=4), then 5 pops
//    -> PC=E0,D0,C0,B0 in turn, then sequential; ras_full=1 after push 4, ras_empty=1 after pop 4.
//  5 PC=0x200, trap_valid=1 with trap_pc=0x1FC, plus redirect_valid and ret_pop
//    -> PC=0x100, epc=0x1FC, RAS flushed; a later mret -> PC=0x1FC.
//  6 RST low mid-stream during a pop -> next PC=RESET_VECTOR, count=0, no RAS effect.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and the next-PC selection encoding for the fetch
// program-counter unit (pc_unit) and its return-address stack (ras_stack).
package pc_pkg;

  localparam int          PC_WIDTH        = 32;
  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VECTOR  = 32'h0000_0100;
  localparam int unsigned PC_INC          = 4;
  localparam int          PC_RAS_DEPTH    = 4;

  // Next-PC source, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    SEL_TRAP  = 3'd0,
    SEL_MRET  = 3'd1,
    SEL_REDIR = 3'd2,
    SEL_HOLD  = 3'd3,
    SEL_RAS   = 3'd4,
    SEL_SEQ   = 3'd5
  } pc_sel_e;

  // The RAS may only change in cycles whose PC comes from the RAS or from the
  // sequential path. Every higher-priority source cancels pending call/return
  // bookkeeping.
  function automatic logic ras_op_allowed(input pc_sel_e sel);
    return (sel == SEL_RAS) || (sel == SEL_SEQ);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack.
//   CLK       in  clock, rising edge
//   RST       in  synchronous active-low reset (count/pointer/entries cleared)
//   flush     in  discard all entries (count -> 0)
//   push      in  push push_data
//   pop       in  pop the top entry (ignored when empty)
//   push_data in  return address to push
//   top       out current top entry (meaningful only when !empty)
//   empty     out count == 0
//   full      out count == RAS_DEPTH
// ptr addresses the next free slot, so the top lives at ptr-1. Pointer
// arithmetic relies on RAS_DEPTH being a power of two, which lets the pointer
// wrap naturally. Pushing onto a full stack overwrites the oldest entry.
module ras_stack
  import pc_pkg::*;
#(
  parameter int WIDTH     = PC_WIDTH,
  parameter int RAS_DEPTH = PC_RAS_DEPTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW:0]      count;
  logic [PW-1:0]    top_idx;

  assign top_idx = ptr - PTR_ONE;
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && pop && !empty) begin
      // The caller consumes the old top this cycle; the new return address
      // takes its slot, so depth is unchanged.
      mem[top_idx] <= push_data;
    end else if (push) begin
      // Also covers push+pop on an empty stack, which acts as a plain push.
      mem[ptr] <= push_data;
      ptr      <= ptr + PTR_ONE;
      if (!full) count <= count + CNT_ONE;
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_ONE;
      count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with trap/mret/redirect/RAS-prediction select.
//   CLK             in  clock, rising edge
//   RST             in  synchronous active-low reset
//   Stall           in  hold PC (cache miss / load-use)
//   trap_valid      in  take trap; trap_pc is saved into epc
//   trap_pc         in  PC of the trapping instruction
//   mret_valid      in  return from trap (PC <= epc)
//   redirect_valid  in  taken branch/jump resolved in EX
//   redirect_target in  EX target address (low two bits forced to zero)
//   call_push       in  decode saw a call; push call_ret_addr
//   call_ret_addr   in  return address to push
//   ret_pop         in  decode saw a return; predict from RAS top
//   PC              out current fetch address
//   PCPlus          out PC + INC, combinational
//   epc             out saved exception PC
//   ras_empty       out RAS holds no entries
//   ras_full        out RAS holds RAS_DEPTH entries
//   misalign_err    out one-cycle pulse after a redirect to a non-word-aligned target
// Priority, highest first: trap, mret, redirect, stall, RAS return, sequential.
// Trap, mret and redirect all override Stall.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(PC_TRAP_VECTOR),
  parameter int unsigned      INC          = PC_INC,
  parameter int               RAS_DEPTH    = PC_RAS_DEPTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Stall,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_pc,
  input  logic             mret_valid,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             call_push,
  input  logic [WIDTH-1:0] call_ret_addr,
  input  logic             ret_pop,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             misalign_err
);

  pc_sel_e          sel;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push;
  logic             ras_pop;
  logic [WIDTH-1:0] pc_next;

  // Wraps modulo 2^WIDTH by construction.
  assign PCPlus = PC + WIDTH'(INC);

  always_comb begin
    sel = SEL_SEQ;
    if (trap_valid)                 sel = SEL_TRAP;
    else if (mret_valid)            sel = SEL_MRET;
    else if (redirect_valid)        sel = SEL_REDIR;
    else if (Stall)                 sel = SEL_HOLD;
    else if (ret_pop && !ras_empty) sel = SEL_RAS;
  end

  always_comb begin
    pc_next = PCPlus;
    case (sel)
      SEL_TRAP:  pc_next = TRAP_VECTOR;
      SEL_MRET:  pc_next = epc;
      SEL_REDIR: pc_next = {redirect_target[WIDTH-1:2], 2'b00};
      SEL_HOLD:  pc_next = PC;
      SEL_RAS:   pc_next = ras_top;
      default:   pc_next = PCPlus;
    endcase
  end

  assign ras_push = call_push && ras_op_allowed(sel);
  assign ras_pop  = ret_pop   && ras_op_allowed(sel);

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (sel == SEL_TRAP),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (call_ret_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      PC           <= RESET_VECTOR;
      epc          <= '0;
      misalign_err <= 1'b0;
    end else begin
      PC           <= pc_next;
      misalign_err <= (sel == SEL_REDIR) && (|redirect_target[1:0]);
      if (sel == SEL_TRAP) epc <= trap_pc;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed bench for pc_unit. Each tick() pushes the expected
// {misalign_err, PC} for the coming edge into exp_q, then pops and compares it
// #1 after that edge. Side outputs are compared directly with chk().
module tb_pc_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Stall;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        mret_valid;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        call_push;
  logic [31:0] call_ret_addr;
  logic        ret_pop;
  logic [31:0] PC;
  logic [31:0] PCPlus;
  logic [31:0] epc;
  logic        ras_empty;
  logic        ras_full;
  logic        misalign_err;

  logic [32:0] exp_q[$];
  int          n_pass  = 0;
  int          n_total = 0;

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  pc_unit dut (
    .CLK             (CLK),
    .RST             (RST),
    .Stall           (Stall),
    .trap_valid      (trap_valid),
    .trap_pc         (trap_pc),
    .mret_valid      (mret_valid),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .call_push       (call_push),
    .call_ret_addr   (call_ret_addr),
    .ret_pop         (ret_pop),
    .PC              (PC),
    .PCPlus          (PCPlus),
    .epc             (epc),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full),
    .misalign_err    (misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic idle();
    Stall           = 1'b0;
    trap_valid      = 1'b0;
    trap_pc         = '0;
    mret_valid      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    call_push       = 1'b0;
    call_ret_addr   = '0;
    ret_pop         = 1'b0;
  endtask

  task automatic tick(input string tag, input logic [31:0] exp_pc, input logic exp_mis);
    logic [32:0] e;
    exp_q.push_back({exp_mis, exp_pc});
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".pc"}, PC, e[31:0]);
    chk({tag, ".misalign"}, {31'b0, misalign_err}, {31'b0, e[32]});
  endtask

  task automatic push_only(input string tag, input logic [31:0] addr, input logic [31:0] exp_pc);
    call_push = 1'b1; call_ret_addr = addr;
    tick(tag, exp_pc, 1'b0);
    call_push = 1'b0;
  endtask

  initial begin
    idle();
    RST = 1'b0;

    // 1: reset then free-running
    tick("reset", 32'h0, 1'b0);
    chk("reset.epc", epc, 32'h0);
    chk("reset.ras_empty", {31'b0, ras_empty}, 32'd1);
    chk("reset.ras_full", {31'b0, ras_full}, 32'd0);
    RST = 1'b1;
    tick("seq1", 32'h4, 1'b0);
    tick("seq2", 32'h8, 1'b0);
    tick("seq3", 32'hC, 1'b0);
    chk("seq3.pcplus", PCPlus, 32'h10);
    tick("seq4", 32'h10, 1'b0);

    // 2: stall, then redirect overriding stall
    Stall = 1'b1;
    tick("stall1", 32'h10, 1'b0);
    redirect_valid = 1'b1; redirect_target = 32'h40;
    tick("stall_redir", 32'h40, 1'b0);
    idle();

    // 3: misaligned redirect, pulse lasts one cycle
    redirect_valid = 1'b1; redirect_target = 32'h42;
    tick("misalign", 32'h40, 1'b1);
    idle();
    tick("misalign_clr", 32'h44, 1'b0);

    // 4: fill past depth, then drain
    push_only("push_a0", 32'hA0, 32'h48);
    push_only("push_b0", 32'hB0, 32'h4C);
    push_only("push_c0", 32'hC0, 32'h50);
    chk("push3.full", {31'b0, ras_full}, 32'd0);
    push_only("push_d0", 32'hD0, 32'h54);
    chk("push4.full", {31'b0, ras_full}, 32'd1);
    push_only("push_e0", 32'hE0, 32'h58);
    chk("push5.full", {31'b0, ras_full}, 32'd1);
    ret_pop = 1'b1;
    tick("pop1", 32'hE0, 1'b0);
    chk("pop1.full", {31'b0, ras_full}, 32'd0);
    tick("pop2", 32'hD0, 1'b0);
    tick("pop3", 32'hC0, 1'b0);
    chk("pop3.empty", {31'b0, ras_empty}, 32'd0);
    tick("pop4", 32'hB0, 1'b0);
    chk("pop4.empty", {31'b0, ras_empty}, 32'd1);
    tick("pop5_empty", 32'hB4, 1'b0);
    chk("pop5.empty", {31'b0, ras_empty}, 32'd1);
    ret_pop = 1'b0;

    // push+pop same cycle, non-empty and empty
    push_only("push_300", 32'h300, 32'hB8);
    call_push = 1'b1; call_ret_addr = 32'h310; ret_pop = 1'b1;
    tick("pushpop_ne", 32'h300, 1'b0);
    call_push = 1'b0;
    tick("pop_310", 32'h310, 1'b0);
    chk("pop_310.empty", {31'b0, ras_empty}, 32'd1);
    call_push = 1'b1; call_ret_addr = 32'h320;
    tick("pushpop_empty", 32'h314, 1'b0);
    call_push = 1'b0;
    chk("pushpop_empty.empty", {31'b0, ras_empty}, 32'd0);
    tick("pop_320", 32'h320, 1'b0);
    ret_pop = 1'b0;

    // stall suppresses a pop
    push_only("push_330", 32'h330, 32'h324);
    Stall = 1'b1; ret_pop = 1'b1;
    tick("stall_pop", 32'h324, 1'b0);
    chk("stall_pop.empty", {31'b0, ras_empty}, 32'd0);
    Stall = 1'b0;
    tick("pop_330", 32'h330, 1'b0);
    ret_pop = 1'b0;

    // 5: trap beats everything and flushes the RAS; mret returns to epc
    push_only("push_350", 32'h350, 32'h334);
    redirect_valid = 1'b1; redirect_target = 32'h200;
    call_push = 1'b1; call_ret_addr = 32'h360;
    tick("redir_200", 32'h200, 1'b0);
    idle();
    chk("redir_200.empty", {31'b0, ras_empty}, 32'd0);
    trap_valid = 1'b1; trap_pc = 32'h1FC;
    mret_valid = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'h83;
    ret_pop = 1'b1;
    tick("trap", 32'h100, 1'b0);
    idle();
    chk("trap.epc", epc, 32'h1FC);
    chk("trap.empty", {31'b0, ras_empty}, 32'd1);
    tick("after_trap", 32'h104, 1'b0);
    ret_pop = 1'b1;
    tick("pop_flushed", 32'h108, 1'b0);
    ret_pop = 1'b0;
    Stall = 1'b1; mret_valid = 1'b1;
    tick("mret", 32'h1FC, 1'b0);
    idle();

    // 6: reset mid-stream during a pop
    push_only("push_400", 32'h400, 32'h200);
    chk("push_400.empty", {31'b0, ras_empty}, 32'd0);
    ret_pop = 1'b1; RST = 1'b0;
    tick("rst_mid", 32'h0, 1'b0);
    chk("rst_mid.epc", epc, 32'h0);
    chk("rst_mid.empty", {31'b0, ras_empty}, 32'd1);
    RST = 1'b1;
    tick("rst_pop", 32'h4, 1'b0);
    ret_pop = 1'b0;

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick("redir_top", 32'hFFFF_FFFC, 1'b0);
    idle();
    chk("redir_top.pcplus", PCPlus, 32'h0);
    tick("wrap", 32'h0, 1'b0);

    chk("scoreboard.drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
